// File: rtl/memory_game_pkg.sv
// Shared definitions for the memory game controller.
// Holds the game state encoding, the field widths used for card indices and
// pair ids, the LFSR feedback mask, and the LFSR step function. The step
// function lets the generator and any other consumer advance the sequence the
// same way.
package memory_game_pkg;

  localparam int PAIR_W = 4;  // pair id width (ids 0..9)
  localparam int IDX_W  = 5;  // card index width (0..19)

  // Galois feedback mask, applied when the bit shifted out is 1
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  typedef enum logic [2:0] {
    ST_SHUFFLE = 3'd0,
    ST_PICK1   = 3'd1,
    ST_PICK2   = 3'd2,
    ST_SHOW    = 3'd3,
    ST_CHECK   = 3'd4,
    ST_WON     = 3'd5,
    ST_LOST    = 3'd6
  } state_e;

  // One right-shifting Galois step
  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    logic [15:0] r;
    if (s[0]) begin
      r = (s >> 1) ^ LFSR_TAPS;
    end else begin
      r = s >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/memory_game_ctrl_lfsr16.sv
// 16-bit Galois LFSR, free-running: it advances on every clock.
// Ports: clock_50M (clock), rst_n (async active-low reset, loads SEED),
//        state (current 16-bit register value).
module lfsr16
  import memory_game_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clock_50M,
  input  logic        rst_n,
  output logic [15:0] state
);

  logic [15:0] state_q;
  logic [15:0] state_d;

  // next value of the sequence
  always_comb begin
    state_d = lfsr_next(state_q);
  end

  // sequence register, only rst_n reloads the seed
  always_ff @(posedge clock_50M or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= SEED;
    end else begin
      state_q <= state_d;
    end
  end

  assign state = state_q;

endmodule

// File: rtl/memory_game_ctrl.sv
// Game sequencing for the 20-card memory game.
// The controller owns the card layout (shuffled in hardware), the cursor, the
// face-up and removed masks, the lives counter and the win/lose outcome. It
// exposes all of this as flat registered vectors for the pixel painter.
// Ports: clock_50M, rst_n (async active-low); frame_tick, btn_select, btn_x and
//        btn_y are one-cycle pulses. cursor is the selected card. card_flipped
//        marks face-up cards and card_out marks removed cards. card_pair holds
//        the pair id of card i at [4*i+:4]. lives, busy (shuffling),
//        game_won and game_lost complete the outputs.
module memory_game_ctrl
  import memory_game_pkg::*;
#(
  parameter int          N_CARDS       = 20,
  parameter int          COLS          = 5,
  parameter int          ROWS          = 4,
  parameter int          LIVES_INIT    = 10,
  parameter int          REVEAL_FRAMES = 30,
  parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
  input  logic                        clock_50M,
  input  logic                        rst_n,
  input  logic                        frame_tick,
  input  logic                        btn_select,
  input  logic                        btn_x,
  input  logic                        btn_y,
  output logic [IDX_W-1:0]            cursor,
  output logic [N_CARDS-1:0]          card_flipped,
  output logic [N_CARDS-1:0]          card_out,
  output logic [PAIR_W*N_CARDS-1:0]   card_pair,
  output logic [3:0]                  lives,
  output logic                        busy,
  output logic                        game_won,
  output logic                        game_lost
);

  localparam int FC_W = (REVEAL_FRAMES > 1) ? $clog2(REVEAL_FRAMES) : 1;

  state_e                     state_q, state_d;
  logic [IDX_W-1:0]           cursor_q, cursor_d;
  logic [IDX_W-1:0]           sel_a_q, sel_a_d;
  logic [IDX_W-1:0]           sel_b_q, sel_b_d;
  logic [IDX_W-1:0]           shuf_idx_q, shuf_idx_d;
  logic [N_CARDS-1:0]         flipped_q, flipped_d;
  logic [N_CARDS-1:0]         out_q, out_d;
  logic [PAIR_W*N_CARDS-1:0]  pair_q, pair_d;
  logic [3:0]                 lives_q, lives_d;
  logic [FC_W-1:0]            frame_cnt_q, frame_cnt_d;
  logic                       busy_q, busy_d;
  logic                       won_q, won_d;
  logic                       lost_q, lost_d;

  logic [15:0]                lfsr_s;
  logic                       lfsr_unused_s;
  logic [12:0]                swap_prod_s;
  logic [IDX_W-1:0]           swap_k_s;
  logic                       pick_ok_s;
  logic                       pairs_equal_s;

  // Unshuffled layout: cards 2j and 2j+1 carry pair id j
  function automatic logic [PAIR_W*N_CARDS-1:0] sorted_pairs();
    logic [PAIR_W*N_CARDS-1:0] r;
    r = {(PAIR_W*N_CARDS){1'b0}};
    for (int i = 0; i < N_CARDS; i++) begin
      r[PAIR_W*i +: PAIR_W] = PAIR_W'(i >> 1);
    end
    return r;
  endfunction

  lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
    .clock_50M (clock_50M),
    .rst_n     (rst_n),
    .state     (lfsr_s)
  );

  // The upper LFSR bits only matter to the generator's own feedback
  assign lfsr_unused_s = ^lfsr_s[15:8];

  // Swap partner: scaling an 8-bit random value by (i+1) and dropping 8 bits keeps k in 0..i
  always_comb begin
    swap_prod_s = {5'd0, lfsr_s[7:0]} * {8'd0, shuf_idx_q + 5'd1};
    swap_k_s    = swap_prod_s[12:8];
  end

  // Shared qualifiers: select validity and pair comparison of the two picks
  always_comb begin
    pick_ok_s     = !flipped_q[cursor_q] && !out_q[cursor_q];
    pairs_equal_s = (pair_q[PAIR_W*sel_a_q +: PAIR_W] == pair_q[PAIR_W*sel_b_q +: PAIR_W]);
  end

  // Next-state logic for the cursor, the game FSM and all registered outputs
  always_comb begin
    state_d     = state_q;
    cursor_d    = cursor_q;
    sel_a_d     = sel_a_q;
    sel_b_d     = sel_b_q;
    shuf_idx_d  = shuf_idx_q;
    flipped_d   = flipped_q;
    out_d       = out_q;
    pair_d      = pair_q;
    lives_d     = lives_q;
    frame_cnt_d = frame_cnt_q;

    // Row step wraps inside the column. Column step wraps from the first column to the last.
    // When both buttons pulse, the row step wins.
    if (btn_y) begin
      if ((cursor_q % IDX_W'(ROWS)) == IDX_W'(ROWS - 1)) begin
        cursor_d = cursor_q - IDX_W'(ROWS - 1);
      end else begin
        cursor_d = cursor_q + 5'd1;
      end
    end else if (btn_x) begin
      if (cursor_q < IDX_W'(ROWS)) begin
        cursor_d = cursor_q + IDX_W'((COLS - 1) * ROWS);
      end else begin
        cursor_d = cursor_q - IDX_W'(ROWS);
      end
    end else begin
      cursor_d = cursor_q;
    end

    case (state_q)
      ST_SHUFFLE: begin
        pair_d[PAIR_W*shuf_idx_q +: PAIR_W] = pair_q[PAIR_W*swap_k_s +: PAIR_W];
        pair_d[PAIR_W*swap_k_s +: PAIR_W]   = pair_q[PAIR_W*shuf_idx_q +: PAIR_W];
        if (shuf_idx_q == 5'd1) begin
          state_d = ST_PICK1;
        end else begin
          shuf_idx_d = shuf_idx_q - 5'd1;
        end
      end
      ST_PICK1: begin
        if (btn_select && pick_ok_s) begin
          flipped_d[cursor_q] = 1'b1;
          sel_a_d             = cursor_q;
          state_d             = ST_PICK2;
        end else begin
          state_d = ST_PICK1;
        end
      end
      ST_PICK2: begin
        // card a is already face-up, so reselecting it fails pick_ok_s
        if (btn_select && pick_ok_s) begin
          flipped_d[cursor_q] = 1'b1;
          sel_b_d             = cursor_q;
          frame_cnt_d         = {FC_W{1'b0}};
          state_d             = ST_SHOW;
        end else begin
          state_d = ST_PICK2;
        end
      end
      ST_SHOW: begin
        if (frame_tick) begin
          if (frame_cnt_q == FC_W'(REVEAL_FRAMES - 1)) begin
            state_d = ST_CHECK;
          end else begin
            frame_cnt_d = frame_cnt_q + {{(FC_W-1){1'b0}}, 1'b1};
          end
        end else begin
          state_d = ST_SHOW;
        end
      end
      ST_CHECK: begin
        flipped_d = {N_CARDS{1'b0}};
        if (pairs_equal_s) begin
          out_d[sel_a_q] = 1'b1;
          out_d[sel_b_q] = 1'b1;
        end else if (lives_q != 4'd0) begin
          lives_d = lives_q - 4'd1;
        end else begin
          lives_d = lives_q;
        end
        // outcome is judged on the values this cycle produces
        if (&out_d) begin
          state_d = ST_WON;
        end else if (lives_d == 4'd0) begin
          state_d = ST_LOST;
        end else begin
          state_d = ST_PICK1;
        end
      end
      ST_WON, ST_LOST: begin
        if (btn_select) begin
          out_d      = {N_CARDS{1'b0}};
          lives_d    = 4'(LIVES_INIT);
          pair_d     = sorted_pairs();
          shuf_idx_d = IDX_W'(N_CARDS - 1);
          state_d    = ST_SHUFFLE;
        end else begin
          state_d = state_q;
        end
      end
      default: begin
        state_d = ST_SHUFFLE;
      end
    endcase

    busy_d = (state_d == ST_SHUFFLE);
    won_d  = (state_d == ST_WON);
    lost_d = (state_d == ST_LOST);
  end

  // Single register bank for FSM state and every output
  always_ff @(posedge clock_50M or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_SHUFFLE;
      cursor_q    <= 5'd0;
      sel_a_q     <= 5'd0;
      sel_b_q     <= 5'd0;
      shuf_idx_q  <= IDX_W'(N_CARDS - 1);
      flipped_q   <= {N_CARDS{1'b0}};
      out_q       <= {N_CARDS{1'b0}};
      pair_q      <= sorted_pairs();
      lives_q     <= 4'(LIVES_INIT);
      frame_cnt_q <= {FC_W{1'b0}};
      busy_q      <= 1'b1;
      won_q       <= 1'b0;
      lost_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cursor_q    <= cursor_d;
      sel_a_q     <= sel_a_d;
      sel_b_q     <= sel_b_d;
      shuf_idx_q  <= shuf_idx_d;
      flipped_q   <= flipped_d;
      out_q       <= out_d;
      pair_q      <= pair_d;
      lives_q     <= lives_d;
      frame_cnt_q <= frame_cnt_d;
      busy_q      <= busy_d;
      won_q       <= won_d;
      lost_q      <= lost_d;
    end
  end

  assign cursor       = cursor_q;
  assign card_flipped = flipped_q;
  assign card_out     = out_q;
  assign card_pair    = pair_q;
  assign lives        = lives_q;
  assign busy         = busy_q;
  assign game_won     = won_q;
  assign game_lost    = lost_q;

endmodule

// File: tb/tb_memory_game_ctrl.sv
// Self-checking bench for memory_game_ctrl.
// Stimulus runs a game-level reference model cycle by cycle. The model is
// built from arrays of cards, a mode number and integer counters. After each
// clock the model's expected outputs go into a scoreboard queue, and a
// separate monitor on the falling edge pops each entry and compares it.
module tb_memory_game_ctrl;

  localparam int          N      = 20;
  localparam int          LIVES0 = 10;
  localparam int          REVEAL = 30;
  localparam logic [15:0] SEED   = 16'hACE1;

  localparam int M_SHUF = 0, M_P1 = 1, M_P2 = 2, M_SHOW = 3, M_CHECK = 4, M_WON = 5, M_LOST = 6;

  logic        clock_50M = 1'b0;
  logic        rst_n = 1'b0;
  logic        frame_tick = 1'b0, btn_select = 1'b0, btn_x = 1'b0, btn_y = 1'b0;
  logic [4:0]  cursor;
  logic [19:0] card_flipped, card_out;
  logic [79:0] card_pair;
  logic [3:0]  lives;
  logic        busy, game_won, game_lost;

  memory_game_ctrl dut (
    .clock_50M    (clock_50M),
    .rst_n        (rst_n),
    .frame_tick   (frame_tick),
    .btn_select   (btn_select),
    .btn_x        (btn_x),
    .btn_y        (btn_y),
    .cursor       (cursor),
    .card_flipped (card_flipped),
    .card_out     (card_out),
    .card_pair    (card_pair),
    .lives        (lives),
    .busy         (busy),
    .game_won     (game_won),
    .game_lost    (game_lost)
  );

  always #5 clock_50M = ~clock_50M;

  typedef struct {
    string       tag;
    logic [4:0]  cursor;
    logic [19:0] flipped;
    logic [19:0] out;
    logic [79:0] pair;
    logic [3:0]  lives;
    logic        busy;
    logic        won;
    logic        lost;
  } snap_t;

  snap_t sb_q[$];
  snap_t mon_e;
  int    checks = 0;
  int    errors = 0;

  // reference model state
  int          m_mode, m_cur, m_lives, m_a, m_b, m_frames, m_si;
  int          m_pair[N];
  bit          m_fl[N];
  bit          m_out[N];
  logic [15:0] m_lfsr;

  function automatic void check(string name, logic [79:0] act, logic [79:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  function automatic void compare_snap(snap_t e);
    check({e.tag, "_cursor"},  80'(cursor),       80'(e.cursor));
    check({e.tag, "_flipped"}, 80'(card_flipped), 80'(e.flipped));
    check({e.tag, "_out"},     80'(card_out),     80'(e.out));
    check({e.tag, "_pair"},    card_pair,         e.pair);
    check({e.tag, "_lives"},   80'(lives),        80'(e.lives));
    check({e.tag, "_busy"},    80'(busy),         80'(e.busy));
    check({e.tag, "_won"},     80'(game_won),     80'(e.won));
    check({e.tag, "_lost"},    80'(game_lost),    80'(e.lost));
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < N; i++) begin
      m_pair[i] = i / 2;
      m_fl[i]   = 1'b0;
      m_out[i]  = 1'b0;
    end
    m_lives = LIVES0; m_cur = 0; m_mode = M_SHUF; m_si = N - 1;
    m_a = 0; m_b = 0; m_frames = 0; m_lfsr = SEED;
  endfunction

  // One clock of game behaviour, taken straight from the rules of play
  function automatic void model_step(bit sel, bit x, bit y, bit tick);
    int  c = m_cur;
    int  k, t;
    bit  all_out;
    case (m_mode)
      M_SHUF: begin
        k = (int'(m_lfsr & 16'h00FF) * (m_si + 1)) / 256;
        t = m_pair[m_si]; m_pair[m_si] = m_pair[k]; m_pair[k] = t;
        m_si--;
        if (m_si == 0) m_mode = M_P1;
      end
      M_P1: if (sel && !m_fl[c] && !m_out[c]) begin m_fl[c] = 1'b1; m_a = c; m_mode = M_P2; end
      M_P2: if (sel && !m_fl[c] && !m_out[c]) begin m_fl[c] = 1'b1; m_b = c; m_frames = 0; m_mode = M_SHOW; end
      M_SHOW: if (tick) begin m_frames++; if (m_frames == REVEAL) m_mode = M_CHECK; end
      M_CHECK: begin
        if (m_pair[m_a] == m_pair[m_b]) begin m_out[m_a] = 1'b1; m_out[m_b] = 1'b1; end
        else m_lives--;
        all_out = 1'b1;
        for (int i = 0; i < N; i++) begin m_fl[i] = 1'b0; all_out &= m_out[i]; end
        if (all_out) m_mode = M_WON;
        else if (m_lives == 0) m_mode = M_LOST;
        else m_mode = M_P1;
      end
      default: if (sel) begin
        for (int i = 0; i < N; i++) begin m_out[i] = 1'b0; m_pair[i] = i / 2; end
        m_lives = LIVES0; m_si = N - 1; m_mode = M_SHUF;
      end
    endcase
    if (y) m_cur = (c % 4 == 3) ? c - 3 : c + 1;
    else if (x) m_cur = (c < 4) ? c + 16 : c - 4;
    m_lfsr = m_lfsr[0] ? ((m_lfsr >> 1) ^ 16'hB400) : (m_lfsr >> 1);
  endfunction

  function automatic snap_t model_snap(string tag);
    snap_t s;
    s.tag    = tag;
    s.cursor = 5'(m_cur);
    for (int i = 0; i < N; i++) begin
      s.flipped[i]   = m_fl[i];
      s.out[i]       = m_out[i];
      s.pair[4*i +: 4] = 4'(m_pair[i]);
    end
    s.lives = 4'(m_lives);
    s.busy  = (m_mode == M_SHUF);
    s.won   = (m_mode == M_WON);
    s.lost  = (m_mode == M_LOST);
    return s;
  endfunction

  task automatic cycle(input bit sel, input bit x, input bit y, input bit tick);
    btn_select = sel; btn_x = x; btn_y = y; frame_tick = tick;
    model_step(sel, x, y, tick);
    @(posedge clock_50M);
    sb_q.push_back(model_snap("cyc"));
    #1;
    btn_select = 1'b0; btn_x = 1'b0; btn_y = 1'b0; frame_tick = 1'b0;
  endtask

  task automatic goto(input int target);
    while (m_cur != target) begin
      if (m_cur % 4 != target % 4) cycle(1'b0, 1'b0, 1'b1, 1'b0);
      else cycle(1'b0, 1'b1, 1'b0, 1'b0);
    end
  endtask

  task automatic rand_moves(input int n);
    for (int i = 0; i < n; i++)
      cycle(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
  endtask

  // Choose and flip two available cards whose ids match (or differ)
  task automatic pick_two(input bit want_match);
    int av[$];
    int cands[$];
    int i, j;
    for (int c = 0; c < N; c++) if (!m_fl[c] && !m_out[c]) av.push_back(c);
    i = av[$urandom_range(0, av.size() - 1)];
    foreach (av[n]) if (av[n] != i && ((m_pair[av[n]] == m_pair[i]) == want_match)) cands.push_back(av[n]);
    if (cands.size() == 0) foreach (av[n]) if (av[n] != i) cands.push_back(av[n]);
    j = cands[$urandom_range(0, cands.size() - 1)];
    goto(i); cycle(1'b1, 1'b0, 1'b0, 1'b0);
    goto(j); cycle(1'b1, 1'b0, 1'b0, 1'b0);
    check("two_face_up", 80'($countones(card_flipped)), 80'd2);
  endtask

  // Reveal period with random ticks, ignored selects and cursor moves, then resolution
  task automatic resolve();
    while (m_mode == M_SHOW)
      cycle(1'($urandom_range(0, 1)), $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 2) != 0);
    while (m_mode == M_CHECK) cycle(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // scoreboard monitor
  always @(negedge clock_50M) begin
    while (sb_q.size() > 0) begin
      mon_e = sb_q.pop_front();
      compare_snap(mon_e);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int cnt[10];
    bit ok;
    model_reset();
    #2 sb_q.push_back(model_snap("reset"));
    #10 rst_n = 1'b1;

    // shuffle with random cursor activity
    rand_moves(N - 1);
    for (int i = 0; i < 10; i++) cnt[i] = 0;
    ok = 1'b1;
    for (int i = 0; i < N; i++) begin
      if (card_pair[4*i +: 4] < 4'd10) cnt[card_pair[4*i +: 4]]++;
      else ok = 1'b0;
    end
    for (int i = 0; i < 10; i++) if (cnt[i] != 2) ok = 1'b0;
    check("pair_multiset", 80'(ok), 80'd1);
    check("shuffle_done_busy", 80'(busy), 80'd0);

    // cursor wrap cases
    goto(3); cycle(1'b0, 1'b0, 1'b1, 1'b0); check("wrap_y", 80'(cursor), 80'd0);
    goto(2); cycle(1'b0, 1'b1, 1'b0, 1'b0); check("wrap_x", 80'(cursor), 80'd18);
    goto(7); cycle(1'b0, 1'b1, 1'b1, 1'b0); check("both_btn", 80'(cursor), 80'd4);

    // one match, one mismatch
    pick_two(1'b1); resolve();
    check("match_lives", 80'(lives), 80'd10);
    check("match_out", 80'($countones(card_out)), 80'd2);
    check("match_flipped", 80'(card_flipped), 80'd0);
    pick_two(1'b0); resolve();
    check("mismatch_lives", 80'(lives), 80'd9);
    check("mismatch_flipped", 80'(card_flipped), 80'd0);

    // lose, then restart
    while (m_mode != M_LOST) begin pick_two(1'b0); resolve(); end
    check("lost_flag", 80'(game_lost), 80'd1);
    check("lost_lives", 80'(lives), 80'd0);
    rand_moves(2);
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    check("restart_busy", 80'(busy), 80'd1);
    check("restart_lives", 80'(lives), 80'd10);
    check("restart_out", 80'(card_out), 80'd0);
    rand_moves(N - 1);

    // win
    while (m_mode != M_WON) begin pick_two(1'b1); resolve(); end
    check("won_flag", 80'(game_won), 80'd1);
    rand_moves(2);

    // restart, then async reset in the middle of a reveal
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    rand_moves(N - 1);
    pick_two(1'b0);
    for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0, 1'b0, 1'b1);
    #6 rst_n = 1'b0;
    model_reset();
    #1 compare_snap(model_snap("async_rst"));
    #10 rst_n = 1'b1;
    rand_moves(6);

    @(negedge clock_50M);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
